// File: rtl/vga_wbuf_pkg.sv
// Shared types and register map for the AHB VGA write buffer.
package vga_wbuf_pkg;

  // Entry fields are sized for the widest legal PIX_AW/DATA_W; narrower instances leave upper bits at zero.
  localparam int unsigned ENTRY_AW = 30;
  localparam int unsigned ENTRY_DW = 32;

  localparam logic [23:0] CONSOLE_OFS = 24'h000000;
  localparam logic [23:0] CTRL_OFS    = 24'h000004;
  localparam logic [23:0] STATUS_OFS  = 24'h000008;
  localparam logic [23:0] STALL_OFS   = 24'h00000C;
  localparam logic [23:0] DRAIN_OFS   = 24'h000010;

  localparam int unsigned STAT_FULL_BIT   = 8;
  localparam int unsigned STAT_EMPTY_BIT  = 9;
  localparam int unsigned STAT_SCROLL_BIT = 10;
  localparam int unsigned STAT_OVF_BIT    = 11;

  localparam int unsigned SPLIT_W   = 10;
  localparam int unsigned OVF_LIMIT = 1023;

  typedef enum logic {
    DEST_CON = 1'b0,
    DEST_IMG = 1'b1
  } dest_e;

  typedef struct packed {
    dest_e                dest;
    logic [ENTRY_AW-1:0]  addr;
    logic [ENTRY_DW-1:0]  data;
  } wbuf_entry_t;

endpackage

// File: rtl/vga_wbuf_fifo.sv
// Synchronous write-buffer FIFO of wbuf_entry_t; pointers carry an extra wrap bit
// so full and empty are distinguishable when the indices match.
module vga_wbuf_fifo
  import vga_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  wbuf_entry_t  wdata,
  input  logic         pop,
  output wbuf_entry_t  rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok, pop_ok;
  wbuf_entry_t mem_q [DEPTH];

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
    if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ahb_vga_wbuf.sv
// AHB-Lite front end for the VGA sinks: console/image writes are queued and drained in order.
// Optional stall/drain counters are built when VGA_WBUF_STATS_EN is defined.
module ahb_vga_wbuf
  import vga_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PIX_AW    = 14,
  parameter int unsigned SPLIT_RST = 240,
  parameter logic [23:0] IMG_BASE  = 24'h001000
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic              scroll,
  output logic              con_we,
  output logic [DATA_W-1:0] con_data,
  output logic              img_we,
  output logic [PIX_AW-1:0] img_addr,
  output logic [DATA_W-1:0] img_data,
  input  logic [9:0]        pixel_x,
  input  logic [DATA_W-1:0] console_rgb,
  input  logic [DATA_W-1:0] image_rgb,
  output logic [DATA_W-1:0] rgb_out
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic               dp_valid_q, dp_valid_d;
  logic               dp_write_q, dp_write_d;
  logic [23:0]        dp_addr_q,  dp_addr_d;
  logic [SPLIT_W-1:0] split_x_q,  split_x_d;
  logic [9:0]         stall_run_q, stall_run_d;
  logic               ovf_q, ovf_d;
  logic               con_we_q, con_we_d, img_we_q, img_we_d;
  logic [DATA_W-1:0]  con_data_q, con_data_d, img_data_q, img_data_d;
  logic [PIX_AW-1:0]  img_addr_q, img_addr_d;

  logic        sel_con, sel_ctrl, sel_status, sel_stats, sel_img;
  logic        push_phase, hready_out, push, pop, wr_ok;
  logic        fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  wbuf_entry_t push_entry, head;
  logic [31:0] status_word, rdata;

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    if (HREADY) begin
      dp_valid_d = HSEL && HTRANS[1];
      dp_write_d = HWRITE;
      dp_addr_d  = HADDR[23:0];
    end
  end

  assign sel_con    = (dp_addr_q == CONSOLE_OFS);
  assign sel_ctrl   = (dp_addr_q == CTRL_OFS);
  assign sel_status = (dp_addr_q == STATUS_OFS);
  assign sel_stats  = (dp_addr_q == STALL_OFS) || (dp_addr_q == DRAIN_OFS);
  assign sel_img    = (dp_addr_q >= IMG_BASE);

  // A full FIFO stalls the push even if the head pops this cycle, keeping HREADYOUT off the pop path.
  assign push_phase = dp_valid_q && dp_write_q && (sel_con || sel_img);
  assign hready_out = !(push_phase && fifo_full);
  assign push       = push_phase && hready_out;
  assign wr_ok      = dp_valid_q && dp_write_q && hready_out;

  always_comb begin
    push_entry      = '0;
    push_entry.dest = sel_img ? DEST_IMG : DEST_CON;
    if (sel_img) push_entry.addr = ENTRY_AW'(dp_addr_q[PIX_AW+1:2]);
    push_entry.data = ENTRY_DW'(HWDATA[DATA_W-1:0]);
  end

  vga_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Image entries never wait; a console head blocks everything behind it while scrolling.
  assign pop = !fifo_empty && ((head.dest == DEST_IMG) || !scroll);

  always_comb begin
    con_we_d   = pop && (head.dest == DEST_CON);
    img_we_d   = pop && (head.dest == DEST_IMG);
    con_data_d = con_we_d ? head.data[DATA_W-1:0] : '0;
    img_data_d = img_we_d ? head.data[DATA_W-1:0] : '0;
    img_addr_d = img_we_d ? head.addr[PIX_AW-1:0] : '0;
  end

  always_comb begin
    split_x_d   = split_x_q;
    stall_run_d = '0;
    ovf_d       = ovf_q;
    if (wr_ok && sel_ctrl) split_x_d = HWDATA[SPLIT_W-1:0];
    if (!hready_out)
      stall_run_d = (stall_run_q == 10'(OVF_LIMIT)) ? stall_run_q : stall_run_q + 10'd1;
    if (wr_ok && sel_status && HWDATA[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (!hready_out && (stall_run_q == 10'(OVF_LIMIT))) ovf_d = 1'b1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      split_x_q   <= SPLIT_W'(SPLIT_RST);
      stall_run_q <= '0;
      ovf_q       <= 1'b0;
      con_we_q    <= 1'b0;
      img_we_q    <= 1'b0;
      con_data_q  <= '0;
      img_data_q  <= '0;
      img_addr_q  <= '0;
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      split_x_q   <= split_x_d;
      stall_run_q <= stall_run_d;
      ovf_q       <= ovf_d;
      con_we_q    <= con_we_d;
      img_we_q    <= img_we_d;
      con_data_q  <= con_data_d;
      img_data_q  <= img_data_d;
      img_addr_q  <= img_addr_d;
    end
  end

`ifdef VGA_WBUF_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (wr_ok && sel_stats) begin
      stall_cnt_d = '0;
      drain_cnt_d = '0;
    end else begin
      if (!hready_out && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (pop && (drain_cnt_q != '1))         drain_cnt_d = drain_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end
`endif

  always_comb begin
    status_word                  = '0;
    status_word[7:0]             = 8'(fifo_level);
    status_word[STAT_FULL_BIT]   = fifo_full;
    status_word[STAT_EMPTY_BIT]  = fifo_empty;
    status_word[STAT_SCROLL_BIT] = scroll;
    status_word[STAT_OVF_BIT]    = ovf_q;
  end

  always_comb begin
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        CTRL_OFS:   rdata = 32'(split_x_q);
        STATUS_OFS: rdata = status_word;
`ifdef VGA_WBUF_STATS_EN
        STALL_OFS:  rdata = stall_cnt_q;
        DRAIN_OFS:  rdata = drain_cnt_q;
`endif
        default:    rdata = '0;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = hready_out;
  assign con_we    = con_we_q;
  assign con_data  = con_data_q;
  assign img_we    = img_we_q;
  assign img_addr  = img_addr_q;
  assign img_data  = img_data_q;
  assign rgb_out   = HRESET ? '0 : ((pixel_x < split_x_q) ? console_rgb : image_rgb);

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:24], HTRANS[0], HWDATA, head, sel_stats};

endmodule

// File: tb/tb_ahb_vga_wbuf.sv
// Directed self-checking bench for ahb_vga_wbuf (DEPTH=8, DATA_W=8, PIX_AW=14).
module tb_ahb_vga_wbuf;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        scroll = 1'b0;
  logic        con_we, img_we;
  logic [7:0]  con_data, img_data;
  logic [13:0] img_addr;
  logic [9:0]  pixel_x = '0;
  logic [7:0]  console_rgb = 8'hA5;
  logic [7:0]  image_rgb = 8'h5A;
  logic [7:0]  rgb_out;

  int total = 0;
  int bad = 0;
  int idle_bad = 0;

  typedef struct packed {
    logic        is_img;
    logic [13:0] addr;
    logic [7:0]  data;
  } ev_t;
  ev_t ev_log[$];

  ahb_vga_wbuf dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .scroll(scroll), .con_we(con_we), .con_data(con_data),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data), .pixel_x(pixel_x),
    .console_rgb(console_rgb), .image_rgb(image_rgb), .rgb_out(rgb_out)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  always @(negedge HCLK) begin
    if (con_we) ev_log.push_back({1'b0, 14'd0, con_data});
    if (img_we) ev_log.push_back({1'b1, img_addr, img_data});
    if (!con_we && con_data !== 8'h00) idle_bad++;
    if (!img_we && (img_data !== 8'h00 || img_addr !== 14'h0)) idle_bad++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    data = HRDATA;
  endtask

  task automatic ahb_write_start(input logic [31:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(negedge HCLK);
  endtask

  task automatic ahb_write_finish(output int stalls);
    stalls = 0;
    while (!HREADYOUT && stalls < 3000) begin
      stalls++;
      @(negedge HCLK);
    end
    if (stalls >= 3000) begin
      total++; bad++;
      $display("FAIL write_timeout stalled=%0d cycles limit=3000", stalls);
    end
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    int s;
    ahb_write_start(addr, data);
    ahb_write_finish(s);
  endtask

  task automatic fill_eight();
    for (int i = 0; i < 8; i++) ahb_write(32'h0, 32'(8'h30 + i));
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    wait_cycles(2);
    total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout got=%0b exp=1", HREADYOUT); end
    total++; if ({con_we, img_we} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {con_we, img_we}); end
    total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
    total++; if (rgb_out !== 8'h00) begin bad++; $display("FAIL reset_rgb got=%h exp=00", rgb_out); end
    @(posedge HCLK); #1; HRESET = 1'b0;
    ahb_read(32'h4, rd);
    total++; if (rd !== 32'd240) begin bad++; $display("FAIL reset_ctrl got=%0d exp=240", rd); end
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'h200) begin bad++; $display("FAIL reset_status got=%h exp=200", rd); end
  endtask

  task automatic test_console_write();
    logic [31:0] rd;
    ev_log.delete();
    ahb_write(32'h0, 32'hFFFF_FF41);
    total++; if (con_we !== 1'b0) begin bad++; $display("FAIL con_t0 got=%0b exp=0", con_we); end
    @(negedge HCLK);
    total++; if (con_we !== 1'b0) begin bad++; $display("FAIL con_t1 got=%0b exp=0", con_we); end
    @(negedge HCLK);
    total++; if ({con_we, con_data} !== {1'b1, 8'h41}) begin bad++; $display("FAIL con_t2 got=%0b/%h exp=1/41", con_we, con_data); end
    @(negedge HCLK);
    total++; if ({con_we, con_data} !== {1'b0, 8'h00}) begin bad++; $display("FAIL con_t3 got=%0b/%h exp=0/00", con_we, con_data); end
    wait_cycles(3);
    total++; if (ev_log.size() !== 1) begin bad++; $display("FAIL con_once got=%0d exp=1", ev_log.size()); end
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'h200) begin bad++; $display("FAIL con_status got=%h exp=200", rd); end
  endtask

  task automatic test_full_stall();
    logic [31:0] rd;
    logic [22:0] exp;
    int s;
    ev_log.delete();
    scroll = 1'b1;
    fill_eight();
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'h508) begin bad++; $display("FAIL full_status got=%h exp=508", rd); end
    ahb_write_start(32'h0, 32'h38);
    total++; if (HREADYOUT !== 1'b0) begin bad++; $display("FAIL full_stall got=%0b exp=0", HREADYOUT); end
    wait_cycles(3);
    total++; if (HREADYOUT !== 1'b0) begin bad++; $display("FAIL full_stall_hold got=%0b exp=0", HREADYOUT); end
    total++; if (ev_log.size() !== 0) begin bad++; $display("FAIL full_no_drain got=%0d exp=0", ev_log.size()); end
    scroll = 1'b0;
    ahb_write_finish(s);
    wait_cycles(15);
    total++; if (ev_log.size() !== 9) begin bad++; $display("FAIL full_count got=%0d exp=9", ev_log.size()); end
    for (int i = 0; i < 9 && i < ev_log.size(); i++) begin
      exp = {1'b0, 14'd0, 8'(8'h30 + i)};
      total++; if (ev_log[i] !== exp) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, ev_log[i], exp); end
    end
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'h200) begin bad++; $display("FAIL full_status_after got=%h exp=200", rd); end
  endtask

  task automatic test_head_of_line();
    logic [31:0] rd;
    ev_log.delete();
    scroll = 1'b1;
    ahb_write(32'h0, 32'h11);
    ahb_write(32'h1004, 32'h22);
    wait_cycles(4);
    total++; if (ev_log.size() !== 0) begin bad++; $display("FAIL hol_blocked got=%0d exp=0", ev_log.size()); end
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'h402) begin bad++; $display("FAIL hol_status got=%h exp=402", rd); end
    scroll = 1'b0;
    wait_cycles(6);
    total++; if (ev_log.size() !== 2) begin bad++; $display("FAIL hol_count got=%0d exp=2", ev_log.size()); end
    if (ev_log.size() == 2) begin
      total++; if (ev_log[0] !== {1'b0, 14'd0, 8'h11}) begin bad++; $display("FAIL hol_first got=%h exp=%h", ev_log[0], {1'b0, 14'd0, 8'h11}); end
      total++; if (ev_log[1] !== {1'b1, 14'h401, 8'h22}) begin bad++; $display("FAIL hol_second got=%h exp=%h", ev_log[1], {1'b1, 14'h401, 8'h22}); end
    end
  endtask

  task automatic test_split();
    logic [31:0] rd;
    pixel_x = 10'd239; #1;
    total++; if (rgb_out !== 8'hA5) begin bad++; $display("FAIL split_239 got=%h exp=a5", rgb_out); end
    pixel_x = 10'd240; #1;
    total++; if (rgb_out !== 8'h5A) begin bad++; $display("FAIL split_240 got=%h exp=5a", rgb_out); end
    ahb_write(32'h4, 32'hFFFF_FC64);
    ahb_read(32'h4, rd);
    total++; if (rd !== 32'd100) begin bad++; $display("FAIL split_ctrl got=%0d exp=100", rd); end
    pixel_x = 10'd99; #1;
    total++; if (rgb_out !== 8'hA5) begin bad++; $display("FAIL split_99 got=%h exp=a5", rgb_out); end
    pixel_x = 10'd100; #1;
    total++; if (rgb_out !== 8'h5A) begin bad++; $display("FAIL split_100 got=%h exp=5a", rgb_out); end
  endtask

  task automatic test_misc_regs();
    logic [31:0] rd;
    ev_log.delete();
    ahb_write(32'h20, 32'h55);
    ahb_write(32'hC, 32'h1234);
    ahb_read(32'h20, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL misc_undef got=%h exp=0", rd); end
    ahb_read(32'h0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL misc_console_rd got=%h exp=0", rd); end
    ahb_read(32'hC, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL misc_stall_cnt got=%h exp=0", rd); end
    ahb_read(32'h10, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL misc_drain_cnt got=%h exp=0", rd); end
    total++; if (ev_log.size() !== 0) begin bad++; $display("FAIL misc_no_push got=%0d exp=0", ev_log.size()); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int s;
    scroll = 1'b1;
    fill_eight();
    ahb_write_start(32'h0, 32'h38);
    wait_cycles(1030);
    scroll = 1'b0;
    ahb_write_finish(s);
    wait_cycles(15);
    ev_log.delete();
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'hA00) begin bad++; $display("FAIL ovf_set got=%h exp=a00", rd); end
    ahb_write(32'h8, 32'h800);
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'h200) begin bad++; $display("FAIL ovf_clear got=%h exp=200", rd); end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] rd;
    scroll = 1'b1;
    fill_eight();
    ahb_write_start(32'h0, 32'h38);
    total++; if (HREADYOUT !== 1'b0) begin bad++; $display("FAIL rst_pre_stall got=%0b exp=0", HREADYOUT); end
    #2 HRESET = 1'b1;
    #1;
    total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%0b exp=1", HREADYOUT); end
    total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
    ev_log.delete();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    scroll = 1'b0;
    wait_cycles(12);
    total++; if (ev_log.size() !== 0) begin bad++; $display("FAIL rst_no_strobes got=%0d exp=0", ev_log.size()); end
    ahb_read(32'h8, rd);
    total++; if (rd !== 32'h200) begin bad++; $display("FAIL rst_status got=%h exp=200", rd); end
    ahb_read(32'h4, rd);
    total++; if (rd !== 32'd240) begin bad++; $display("FAIL rst_ctrl got=%0d exp=240", rd); end
  endtask

  initial begin
    test_reset();
    test_console_write();
    test_full_stall();
    test_head_of_line();
    test_split();
    test_misc_regs();
    test_overflow();
    test_reset_mid_stall();
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL idle_data_zero got=%0d exp=0", idle_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
